// File: rtl/idct_2d.sv
// idct_2d
//   8x8 two-dimensional inverse DCT. A single 8-point 1-D IDCT is shared by
//   both passes. The row pass handles one row per cycle and writes to a
//   16-bit row buffer. The column pass handles one column per cycle and writes
//   to the pixel register. Latency is 1 accept cycle + 8 row cycles + 8 column
//   cycles, followed by OUT. The shortest block period is 18 cycles.
//
//   Optional feature macro: IDCT_LEVEL_SHIFT_EN
//     defined   : pixel = clamp(col_result + 128, 0, 255)      (unsigned)
//     undefined : pixel = clamp(col_result, -128, 127)         (two's complement)
//
// Ports
//   clock      in    1   rising-edge clock
//   reset_n    in    1   asynchronous active-low reset
//   coef_in    in  768   X[r][c] signed 12-bit at [12*(r*8+c) +: 12]
//   in_valid   in    1   coefficient block offered
//   in_ready   out   1   block accepted when in_valid && in_ready (IDLE only)
//   pix_out    out 512   P[r][c] 8-bit at [8*(r*8+c) +: 8], stable while out_valid
//   out_valid  out   1   pixel block available (OUT state)
//   out_ready  in    1   consumer takes the pixel block
//
// state | meaning
// IDLE  | in_ready=1, waiting for a coefficient block
// ROW   | 1-D IDCT of captured row idx -> row_buf[idx]
// COL   | 1-D IDCT of row_buf column idx -> pixel column idx
// OUT   | out_valid=1, pix_out held until out_ready
module idct_2d (
  input  logic         clock,
  input  logic         reset_n,
  input  logic [767:0] coef_in,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [511:0] pix_out,
  output logic         out_valid,
  input  logic         out_ready
);

  typedef enum logic [1:0] {IDLE, ROW, COL, OUT} state_t;

  state_t     state, state_nxt;
  logic [2:0] idx, idx_nxt;
  logic       capture;

  logic signed [11:0] coef_q  [8][8];
  logic signed [15:0] row_buf [8][8];
  logic        [7:0]  pix_q   [8][8];

  logic signed [31:0] x_in    [8];
  logic signed [31:0] acc     [8];
  logic signed [31:0] y_out   [8];
  logic signed [15:0] row_sat [8];
  logic        [7:0]  col_pix [8];
`ifdef IDCT_LEVEL_SHIFT_EN
  logic signed [31:0] shifted [8];
`endif

  // 2048*cos(i*pi/16), i = 0..8
  function automatic logic signed [31:0] cbase(input int i);
    case (i)
      0:       return 32'sd2048;
      1:       return 32'sd2009;
      2:       return 32'sd1892;
      3:       return 32'sd1703;
      4:       return 32'sd1448;
      5:       return 32'sd1138;
      6:       return 32'sd784;
      7:       return 32'sd400;
      default: return 32'sd0;
    endcase
  endfunction

  // K[k][n] = round(4096*c(k)/2*cos((2n+1)k*pi/16)). The angle is folded into
  // the first quadrant using the symmetry of cosine.
  function automatic logic signed [31:0] kcoef(input int k, input int n);
    int m;
    if (k == 0) return 32'sd1448;
    m = ((2 * n + 1) * k) % 32;
    if (m <= 8)       return cbase(m);
    else if (m <= 16) return -cbase(16 - m);
    else if (m <= 24) return -cbase(m - 16);
    else              return cbase(32 - m);
  endfunction

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      idx   <= 3'd0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    capture   = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          capture   = 1'b1;
          state_nxt = ROW;
          idx_nxt   = 3'd0;
        end
      end
      ROW: begin
        idx_nxt = idx + 3'd1;
        if (idx == 3'd7) state_nxt = COL;
      end
      COL: begin
        idx_nxt = idx + 3'd1;
        if (idx == 3'd7) state_nxt = OUT;
      end
      OUT: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // ------------------------------------------------------ shared 1-D IDCT
  always_comb begin
    for (int k = 0; k < 8; k++) begin
      if (state == COL) x_in[k] = 32'(row_buf[k][idx]);
      else              x_in[k] = 32'(coef_q[idx][k]);
    end
  end

  always_comb begin
    for (int n = 0; n < 8; n++) begin
      acc[n] = 32'sd2048;
      for (int k = 0; k < 8; k++) begin
        acc[n] = acc[n] + x_in[k] * kcoef(k, n);
      end
      y_out[n] = acc[n] >>> 12;
    end
  end

  // Row results saturate to 16 bits; column results become 8-bit pixels.
  always_comb begin
    for (int n = 0; n < 8; n++) begin
      if (y_out[n] > 32'sd32767)       row_sat[n] = 16'sh7FFF;
      else if (y_out[n] < -32'sd32768) row_sat[n] = 16'sh8000;
      else                             row_sat[n] = y_out[n][15:0];
`ifdef IDCT_LEVEL_SHIFT_EN
      shifted[n] = y_out[n] + 32'sd128;
      if (shifted[n] > 32'sd255)    col_pix[n] = 8'd255;
      else if (shifted[n] < 32'sd0) col_pix[n] = 8'd0;
      else                          col_pix[n] = shifted[n][7:0];
`else
      if (y_out[n] > 32'sd127)       col_pix[n] = 8'h7F;
      else if (y_out[n] < -32'sd128) col_pix[n] = 8'h80;
      else                           col_pix[n] = y_out[n][7:0];
`endif
    end
  end

  // ------------------------------------------------------------ storage
  // The coefficient latch and row buffer need no reset. Their contents
  // matter only after capture.
  always_ff @(posedge clock) begin
    if (capture) begin
      for (int r = 0; r < 8; r++)
        for (int c = 0; c < 8; c++)
          coef_q[r][c] <= coef_in[12*(r*8+c) +: 12];
    end
    if (state == ROW) begin
      for (int n = 0; n < 8; n++) row_buf[idx][n] <= row_sat[n];
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int r = 0; r < 8; r++)
        for (int c = 0; c < 8; c++)
          pix_q[r][c] <= 8'd0;
    end else if (state == COL) begin
      for (int n = 0; n < 8; n++) pix_q[n][idx] <= col_pix[n];
    end
  end

  for (genvar r = 0; r < 8; r++) begin : g_row
    for (genvar c = 0; c < 8; c++) begin : g_col
      assign pix_out[8*(r*8+c) +: 8] = pix_q[r][c];
    end
  end

endmodule

// File: tb/tb_idct_2d.sv
// Directed bench for idct_2d, plus a short back-to-back run checked against
// a reference model. The model derives its cosine table from $cos.
module tb_idct_2d;

  logic         clock = 1'b0;
  logic         reset_n = 1'b0;
  logic [767:0] coef_in = '0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [511:0] pix_out;
  logic         out_valid;
  logic         out_ready = 1'b0;

  idct_2d dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .coef_in   (coef_in),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .pix_out   (pix_out),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

`ifdef IDCT_LEVEL_SHIFT_EN
  localparam int OFS = 128;
  localparam logic [7:0] PIX_HI = 8'd255;
  localparam logic [7:0] PIX_LO = 8'd0;
`else
  localparam int OFS = 0;
  localparam logic [7:0] PIX_HI = 8'h7F;
  localparam logic [7:0] PIX_LO = 8'h80;
`endif

  logic [511:0] exp_v;
  int kt [8][8];
  int mx [8][8];
  int mr [8][8];

  // ------------------------------------------------------------ helpers
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_x(input int r, input int c, input int v);
    coef_in[12*(r*8+c) +: 12] = 12'(v);
  endtask

  task automatic fill_exp(input logic [7:0] b);
    for (int i = 0; i < 64; i++) exp_v[8*i +: 8] = b;
  endtask

  // Offers coef_in once in_ready is high; returns the cycle number of the accepting edge.
  task automatic send(output int acc_cyc);
    int n;
    n = 0;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    checks++;
    if (!in_ready) begin
      failures++;
      $display("FAIL send_timeout: in_ready got 0 want 1 after %0d cycles", n);
      acc_cyc = cyc;
    end else begin
      in_valid = 1'b1;
      tick();
      acc_cyc = cyc;
      in_valid = 1'b0;
    end
  endtask

  // lat counts cycles, with the accepting edge counted as cycle 1.
  task automatic wait_valid(output int lat);
    lat = 1;
    while (!out_valid && lat < 40) begin
      tick();
      lat++;
    end
  endtask

  function automatic int rnd(input real x);
    if (x >= 0.0) return $rtoi(x + 0.5);
    else          return -$rtoi(-x + 0.5);
  endfunction

  task automatic init_k();
    real pi, ck;
    pi = 3.14159265358979;
    for (int k = 0; k < 8; k++) begin
      ck = (k == 0) ? (1.0 / $sqrt(2.0)) : 1.0;
      for (int n = 0; n < 8; n++)
        kt[k][n] = rnd(4096.0 * ck / 2.0 * $cos(real'((2 * n + 1) * k) * pi / 16.0));
    end
  endtask

  function automatic logic [7:0] post(input int y);
    int v;
`ifdef IDCT_LEVEL_SHIFT_EN
    v = y + 128;
    if (v > 255) v = 255;
    if (v < 0)   v = 0;
`else
    v = y;
    if (v > 127)  v = 127;
    if (v < -128) v = -128;
`endif
    return v[7:0];
  endfunction

  task automatic model_block();
    int a, y;
    for (int r = 0; r < 8; r++)
      for (int n = 0; n < 8; n++) begin
        a = 2048;
        for (int k = 0; k < 8; k++) a = a + kt[k][n] * mx[r][k];
        y = a >>> 12;
        if (y > 32767)  y = 32767;
        if (y < -32768) y = -32768;
        mr[r][n] = y;
      end
    for (int j = 0; j < 8; j++)
      for (int n = 0; n < 8; n++) begin
        a = 2048;
        for (int k = 0; k < 8; k++) a = a + kt[k][n] * mr[k][j];
        y = a >>> 12;
        exp_v[8*(n*8+j) +: 8] = post(y);
      end
  endtask

  // Worked by hand for X[0][1]=64: row 0 is {31,27,18,6,-6,-18,-27,-31}, and every
  // pixel row becomes {11,10,6,2,-2,-6,-10,-11} before post-processing.
  task automatic exp_ac();
    int ac [8];
    int v;
    ac = '{11, 10, 6, 2, -2, -6, -10, -11};
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) begin
        v = ac[c] + OFS;
        exp_v[8*(r*8+c) +: 8] = v[7:0];
      end
  endtask

  // -------------------------------------------------------------- tests
  task automatic test_reset();
    reset_n = 1'b0;
    #12;
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_out_valid: got %b want 0", out_valid);
    end
    checks++;
    if (pix_out !== 512'd0) begin
      failures++;
      $display("FAIL reset_pix: got %h want 0", pix_out);
    end
    #10 reset_n = 1'b1;
    tick();
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_in_ready: got %b want 1", in_ready);
    end
  endtask

  task automatic test_zero();
    int a, lat;
    coef_in = '0;
    out_ready = 1'b1;
    send(a);
    wait_valid(lat);
    checks++;
    if (lat !== 17) begin
      failures++;
      $display("FAIL lat_zero: got %0d want 17", lat);
    end
    fill_exp(8'(OFS));
    checks++;
    if (pix_out !== exp_v) begin
      failures++;
      $display("FAIL pix_zero: got %h want %h", pix_out, exp_v);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL zero_handshake: got out_valid=%b in_ready=%b want 0/1", out_valid, in_ready);
    end
  endtask

  task automatic test_dc();
    int a, lat;
    coef_in = '0;
    set_x(0, 0, 64);
    send(a);
    wait_valid(lat);
    checks++;
    if (lat !== 17) begin
      failures++;
      $display("FAIL lat_dc: got %0d want 17", lat);
    end
    fill_exp(8'(OFS + 8));
    checks++;
    if (pix_out !== exp_v) begin
      failures++;
      $display("FAIL pix_dc: got %h want %h", pix_out, exp_v);
    end
    tick();
  endtask

  task automatic test_clamp();
    int a, lat;
    coef_in = '0;
    set_x(0, 0, 2047);
    send(a);
    wait_valid(lat);
    fill_exp(PIX_HI);
    checks++;
    if (pix_out !== exp_v) begin
      failures++;
      $display("FAIL pix_clamp_hi: got %h want %h", pix_out, exp_v);
    end
    tick();
    set_x(0, 0, -2048);
    send(a);
    wait_valid(lat);
    fill_exp(PIX_LO);
    checks++;
    if (pix_out !== exp_v) begin
      failures++;
      $display("FAIL pix_clamp_lo: got %h want %h", pix_out, exp_v);
    end
    tick();
  endtask

  task automatic test_ac();
    int a, lat;
    coef_in = '0;
    set_x(0, 1, 64);
    send(a);
    wait_valid(lat);
    exp_ac();
    checks++;
    if (pix_out !== exp_v) begin
      failures++;
      $display("FAIL pix_ac: got %h want %h", pix_out, exp_v);
    end
    tick();
  endtask

  task automatic test_stall();
    int a, lat;
    logic [511:0] snap;
    out_ready = 1'b0;
    coef_in = '0;
    set_x(0, 0, 64);
    send(a);
    // A competing block is offered for the whole computation and stall.
    set_x(0, 0, -2048);
    set_x(3, 5, 1000);
    in_valid = 1'b1;
    wait_valid(lat);
    checks++;
    if (lat !== 17) begin
      failures++;
      $display("FAIL lat_stall: got %0d want 17", lat);
    end
    fill_exp(8'(OFS + 8));
    checks++;
    if (pix_out !== exp_v) begin
      failures++;
      $display("FAIL pix_stall: got %h want %h", pix_out, exp_v);
    end
    snap = pix_out;
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
        failures++;
        $display("FAIL stall_flags[%0d]: got out_valid=%b in_ready=%b want 1/0", i, out_valid, in_ready);
      end
      checks++;
      if (pix_out !== snap) begin
        failures++;
        $display("FAIL stall_pix[%0d]: got %h want %h", i, pix_out, snap);
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL stall_release: got out_valid=%b in_ready=%b want 0/1", out_valid, in_ready);
    end
  endtask

  task automatic test_reset_mid_col();
    int a, lat;
    out_ready = 1'b1;
    coef_in = '0;
    set_x(0, 0, 64);
    send(a);
    // After 12 more edges the FSM is in COL with index 4.
    for (int i = 0; i < 12; i++) tick();
    reset_n = 1'b0;
    #2 reset_n = 1'b1;
    for (int i = 0; i < 25; i++) begin
      tick();
      checks++;
      if (out_valid !== 1'b0) begin
        failures++;
        $display("FAIL abort_valid[%0d]: got %b want 0", i, out_valid);
      end
    end
    checks++;
    if (in_ready !== 1'b1 || pix_out !== 512'd0) begin
      failures++;
      $display("FAIL abort_state: got in_ready=%b pix=%h want 1/0", in_ready, pix_out);
    end
    coef_in = '0;
    set_x(0, 1, 64);
    send(a);
    wait_valid(lat);
    checks++;
    if (lat !== 17) begin
      failures++;
      $display("FAIL lat_after_abort: got %0d want 17", lat);
    end
    exp_ac();
    checks++;
    if (pix_out !== exp_v) begin
      failures++;
      $display("FAIL pix_after_abort: got %h want %h", pix_out, exp_v);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    int a, prev, lat, span;
    out_ready = 1'b1;
    prev = 0;
    for (int b = 0; b < 4; b++) begin
      span = (b < 2) ? 4095 : 127;
      for (int r = 0; r < 8; r++)
        for (int c = 0; c < 8; c++) begin
          mx[r][c] = int'($urandom_range(span)) - (span + 1) / 2;
          set_x(r, c, mx[r][c]);
        end
      model_block();
      send(a);
      if (b > 0) begin
        checks++;
        if (a - prev !== 18) begin
          failures++;
          $display("FAIL period[%0d]: got %0d want 18", b, a - prev);
        end
      end
      prev = a;
      wait_valid(lat);
      checks++;
      if (lat !== 17) begin
        failures++;
        $display("FAIL lat_b2b[%0d]: got %0d want 17", b, lat);
      end
      checks++;
      if (pix_out !== exp_v) begin
        failures++;
        $display("FAIL pix_b2b[%0d]: got %h want %h", b, pix_out, exp_v);
      end
    end
    tick();
  endtask

  initial begin
    init_k();
    test_reset();
    test_zero();
    test_dc();
    test_clamp();
    test_ac();
    test_stall();
    test_reset_mid_col();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/idct_2d.md
IDCT_2D -- requirements
Module: idct_2d

Interface
REQ-001 SHALL have ports: clock (in, 1): rising-edge clock; reset_n (in, 1): reset, asynchronous, active-low.
REQ-002 SHALL have coef_in (in, 768): 8x8 signed 12-bit coefficients; X[r][c] occupies bits [12*(r*8+c) +: 12].
REQ-003 SHALL have in_valid (in, 1) and in_ready (out, 1): coefficient-block handshake.
REQ-004 SHALL have pix_out (out, 512): 8x8 8-bit pixels; P[r][c] occupies bits [8*(r*8+c) +: 8].
REQ-005 SHALL have out_valid (out, 1) and out_ready (in, 1): pixel-block handshake.

Function
REQ-006 SHALL implement the FSM states IDLE, ROW, COL and OUT, with a 3-bit index counter used in ROW and COL.
REQ-007 IDLE SHALL assert in_ready=1; on in_valid&&in_ready it SHALL capture coef_in and go to ROW with index=0.
REQ-008 ROW SHALL apply one shared 1-D IDCT to input row index per cycle, write the result to row buffer[index], and go to COL after index 7.
REQ-009 COL SHALL apply the same 1-D IDCT to column index of the row buffer per cycle, write result to column j=index, and go to OUT after index 7.
REQ-010 OUT SHALL hold out_valid=1 with pix_out stable until out_ready=1, then return to IDLE; in_ready SHALL be 0 in ROW, COL and OUT.
REQ-011 out_valid SHALL rise 17 cycles after the accepting edge; minimum block period is 18 cycles.
REQ-012 1-D IDCT SHALL compute y[n] = (sum over k of K[k][n]*x[k] + 2048) >>> 12 (arithmetic shift), using a 32-bit signed accumulator.
REQ-013 K[k][n] SHALL equal round(4096*c(k)/2*cos((2n+1)k*pi/16)), where c(0)=1/sqrt(2) and c(k>0)=1; therefore K[0][n]=1448.
REQ-014 Row-pass results SHALL be saturated to signed 16 bits before storage.
REQ-015 Column-pass results SHALL be post-processed per REQ-019/REQ-020 into 8 bits.
REQ-016 in_valid asserted outside IDLE SHALL be ignored; the captured block SHALL NOT change mid-computation.

Reset
REQ-017 On reset_n=0: state=IDLE, index=0, out_valid=0, pix_out=0, and row buffer contents don't-care; in_ready SHALL be 1 one cycle after reset release.
REQ-018 Reset asserted in ROW, COL or OUT SHALL abort the block immediately; no partial output SHALL ever be flagged valid.

Configuration
REQ-019 With IDCT_LEVEL_SHIFT_EN defined, the column result SHALL be increased by 128 and clamped to 0..255 (unsigned pixel).
REQ-020 Without IDCT_LEVEL_SHIFT_EN, the column result SHALL be clamped to -128..127 and output as 8-bit two's complement.

Verification (IDCT_LEVEL_SHIFT_EN defined unless stated)
REQ-021 All-zero coefficients -> all 64 pixels = 128; out_valid exactly 17 cycles after accept.
REQ-022 X[0][0]=64, others 0 -> row pass gives 23; all pixels = 136 (without macro: 8).
REQ-023 X[0][0]=2047 -> pixels clamp to 255; X[0][0]=-2048 -> pixels clamp to 0.
REQ-024 out_ready held 0 for 10 cycles -> pix_out stable, in_ready=0, and a second in_valid is not accepted; release -> IDLE next cycle.
REQ-025 reset_n pulsed during COL index 4 -> out_valid stays 0, then the next block computes correctly.
REQ-026 Random coefficients in -2048..2047, back-to-back blocks -> match a bit-exact model of REQ-012..REQ-015.
